pwm_update_ctrl: RTL and testbench

Run and configuration controller for the PWM timebase. It starts and stops the 12-bit up-counter through `Clk_en` and `Load_en`/`Load`. It also drives the period and compare values used by the timebase comparators. New period/compare pairs are written through a valid/ready handshake into shadow registers and applied atomically at the counter-zero boundary (`Ctr_0`), so an update never produces a truncated or glitched PWM cycle.

---
 rtl/pwm_update_ctrl_if.sv | 24 ++
 rtl/pwm_update_ctrl.sv | 129 ++++++++++++
 tb/tb_pwm_update_ctrl.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/pwm_update_ctrl_if.sv
// Configuration handshake bundle for pwm_update_ctrl: a period/compare pair
// offered with valid/ready.
interface pwm_update_ctrl_if #(
  parameter int WIDTH = 12
);
  logic             cfg_valid;
  logic             cfg_ready;
  logic [WIDTH-1:0] cfg_period;
  logic [WIDTH-1:0] cfg_compare;

  modport master (
    output cfg_valid,
    output cfg_period,
    output cfg_compare,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_period,
    input  cfg_compare,
    output cfg_ready
  );
endinterface

// File: rtl/pwm_update_ctrl.sv
// Run/stop controller for the PWM timebase with shadowed period/compare
// registers that are applied atomically at the counter-zero boundary.
module pwm_update_ctrl #(
  parameter int WIDTH      = 12,
  parameter int DEF_PERIOD = 1000,
  parameter int DEF_CMP    = 20
) (
  input  logic             Clock,
  input  logic             Rst,
  input  logic             start,
  input  logic             stop,
  pwm_update_ctrl_if.slave cfg,
  input  logic             Ctr_0,
  output logic             Clk_en,
  output logic             Load_en,
  output logic [WIDTH-1:0] Load,
  output logic [WIDTH-1:0] period,
  output logic [WIDTH-1:0] compare,
  output logic             busy,
  output logic             upd_done
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRELOAD = 2'd1,
    RUN     = 2'd2,
    DRAIN   = 2'd3
  } state_e;

  localparam logic [WIDTH-1:0] ONE_C = {{(WIDTH-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic             pending_q, pending_d;
  logic [WIDTH-1:0] sh_period_q, sh_period_d;
  logic [WIDTH-1:0] sh_cmp_q, sh_cmp_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic [WIDTH-1:0] compare_q, compare_d;
  logic [WIDTH-1:0] load_q, load_d;
  logic             clk_en_q, clk_en_d;
  logic             load_en_q, load_en_d;
  logic             upd_done_q, upd_done_d;

  logic             xfer_s;
  logic             apply_s;
  logic [WIDTH-1:0] san_period_s;
  logic [WIDTH-1:0] san_cmp_s;

  // Next-state, shadow capture/apply and registered-output decode
  always_comb begin
    state_d      = state_q;
    pending_d    = pending_q;
    sh_period_d  = sh_period_q;
    sh_cmp_d     = sh_cmp_q;
    period_d     = period_q;
    compare_d    = compare_q;
    load_d       = {WIDTH{1'b0}};
    upd_done_d   = 1'b0;

    xfer_s       = cfg.cfg_valid && !pending_q;
    san_period_s = (cfg.cfg_period == {WIDTH{1'b0}}) ? ONE_C : cfg.cfg_period;
    san_cmp_s    = (cfg.cfg_compare > san_period_s) ? san_period_s : cfg.cfg_compare;
    // Outside a running cycle there is no waveform to protect, so apply at once
    apply_s      = pending_q && ((state_q == IDLE) || (state_q == PRELOAD) || Ctr_0);

    case (state_q)
      IDLE:    if (start && !stop) state_d = PRELOAD; else state_d = IDLE;
      PRELOAD: state_d = RUN;
      RUN: begin
        if (stop) state_d = Ctr_0 ? IDLE : DRAIN;
        else      state_d = RUN;
      end
      DRAIN:   if (Ctr_0) state_d = IDLE; else state_d = DRAIN;
      default: state_d = IDLE;
    endcase

    if (apply_s) begin
      period_d   = sh_period_q;
      compare_d  = sh_cmp_q;
      pending_d  = 1'b0;
      upd_done_d = 1'b1;
    end else if (xfer_s) begin
      sh_period_d = san_period_s;
      sh_cmp_d    = san_cmp_s;
      pending_d   = 1'b1;
    end else begin
      pending_d = pending_q;
    end

    clk_en_d  = (state_d == RUN) || (state_d == DRAIN);
    load_en_d = (state_d == PRELOAD);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge Clock) begin
    if (Rst) begin
      state_q     <= IDLE;
      pending_q   <= 1'b0;
      sh_period_q <= {WIDTH{1'b0}};
      sh_cmp_q    <= {WIDTH{1'b0}};
      period_q    <= WIDTH'(DEF_PERIOD);
      compare_q   <= WIDTH'(DEF_CMP);
      load_q      <= {WIDTH{1'b0}};
      clk_en_q    <= 1'b0;
      load_en_q   <= 1'b0;
      upd_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      sh_period_q <= sh_period_d;
      sh_cmp_q    <= sh_cmp_d;
      period_q    <= period_d;
      compare_q   <= compare_d;
      load_q      <= load_d;
      clk_en_q    <= clk_en_d;
      load_en_q   <= load_en_d;
      upd_done_q  <= upd_done_d;
    end
  end

  assign cfg.cfg_ready = !pending_q;
  assign busy          = (state_q != IDLE);
  assign Clk_en        = clk_en_q;
  assign Load_en       = load_en_q;
  assign Load          = load_q;
  assign period        = period_q;
  assign compare       = compare_q;
  assign upd_done      = upd_done_q;

endmodule

// File: tb/tb_pwm_update_ctrl.sv
// Bench for pwm_update_ctrl: directed literal checks plus randomized traffic
// compared every cycle against a behavioural model.
module tb_pwm_update_ctrl;

  logic        Clock = 1'b0;
  logic        Rst, start, stop, Ctr_0;
  logic        Clk_en, Load_en, busy, upd_done;
  logic [11:0] Load, period, compare;

  int checks   = 0;
  int failures = 0;

  pwm_update_ctrl_if #(.WIDTH(12)) cfg_if ();

  pwm_update_ctrl #(.WIDTH(12), .DEF_PERIOD(1000), .DEF_CMP(20)) dut (
    .Clock(Clock), .Rst(Rst), .start(start), .stop(stop), .cfg(cfg_if),
    .Ctr_0(Ctr_0), .Clk_en(Clk_en), .Load_en(Load_en), .Load(Load),
    .period(period), .compare(compare), .busy(busy), .upd_done(upd_done)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Behavioural model: mode 0 idle, 1 preload, 2 running, 3 draining
  bit          m_ok = 1'b0;
  int          m_mode;
  bit          m_pend, m_upd;
  int          m_per, m_cmp, m_sp, m_sc;

  always @(posedge Clock) begin
    bit do_apply, do_xfer;
    int p;
    if (Rst) begin
      m_ok = 1'b1; m_mode = 0; m_pend = 1'b0; m_upd = 1'b0;
      m_per = 1000; m_cmp = 20;
    end else if (m_ok) begin
      do_apply = m_pend && (m_mode <= 1 || Ctr_0);
      do_xfer  = cfg_if.cfg_valid && !m_pend;
      m_upd    = do_apply;
      if (do_apply) begin
        m_per = m_sp; m_cmp = m_sc; m_pend = 1'b0;
      end
      if (do_xfer) begin
        p    = int'(cfg_if.cfg_period);
        if (p < 1) p = 1;
        m_sp = p;
        m_sc = (int'(cfg_if.cfg_compare) > p) ? p : int'(cfg_if.cfg_compare);
        m_pend = 1'b1;
      end
      case (m_mode)
        0: if (start && !stop) m_mode = 1;
        1: m_mode = 2;
        2: if (stop) m_mode = Ctr_0 ? 0 : 3;
        3: if (Ctr_0) m_mode = 0;
        default: m_mode = 0;
      endcase
    end
  end

  // Every-cycle comparison of all outputs against the model
  always @(negedge Clock) begin
    if (m_ok) begin
      chk("m_clk_en",   Clk_en,  (m_mode >= 2));
      chk("m_load_en",  Load_en, (m_mode == 1));
      chk("m_load",     Load,    0);
      chk("m_busy",     busy,    (m_mode != 0));
      chk("m_cfg_rdy",  cfg_if.cfg_ready, !m_pend);
      chk("m_period",   period,  m_per);
      chk("m_compare",  compare, m_cmp);
      chk("m_upd_done", upd_done, m_upd);
    end
  end

  task automatic step();
    @(posedge Clock);
    @(negedge Clock);
  endtask

  task automatic offer(input int per, input int cmp);
    cfg_if.cfg_valid   = 1'b1;
    cfg_if.cfg_period  = 12'(per);
    cfg_if.cfg_compare = 12'(cmp);
  endtask

  initial begin
    Rst = 1'b1; start = 1'b0; stop = 1'b0; Ctr_0 = 1'b0;
    cfg_if.cfg_valid = 1'b0; cfg_if.cfg_period = 12'd0; cfg_if.cfg_compare = 12'd0;
    step();
    Rst = 1'b0;
    chk("rst_period", period, 1000);
    chk("rst_compare", compare, 20);
    chk("rst_clk_en", Clk_en, 0);
    chk("rst_cfg_ready", cfg_if.cfg_ready, 1);
    chk("rst_busy", busy, 0);

    // Start latency
    start = 1'b1;
    step();
    start = 1'b0;
    chk("start_load_en", Load_en, 1);
    chk("start_load", Load, 0);
    chk("start_clk_en_early", Clk_en, 0);
    chk("start_busy", busy, 1);
    step();
    chk("start_clk_en", Clk_en, 1);
    chk("start_load_en_off", Load_en, 0);

    // Running update waits for the boundary
    offer(500, 100);
    step();
    cfg_if.cfg_valid = 1'b0;
    chk("run_upd_ready_low", cfg_if.cfg_ready, 0);
    chk("run_upd_hold", period, 1000);
    step();
    chk("run_upd_hold2", period, 1000);
    Ctr_0 = 1'b1;
    step();
    Ctr_0 = 1'b0;
    chk("run_upd_period", period, 500);
    chk("run_upd_compare", compare, 100);
    chk("run_upd_pulse", upd_done, 1);
    chk("run_upd_ready", cfg_if.cfg_ready, 1);
    step();
    chk("run_upd_pulse_end", upd_done, 0);

    // Transfer coinciding with Ctr_0 is not applied; period 0 sanitised
    offer(0, 7);
    Ctr_0 = 1'b1;
    step();
    cfg_if.cfg_valid = 1'b0;
    Ctr_0 = 1'b0;
    chk("same_edge_no_apply", period, 500);
    chk("same_edge_no_pulse", upd_done, 0);
    Ctr_0 = 1'b1;
    step();
    Ctr_0 = 1'b0;
    chk("san_zero_period", period, 1);
    chk("san_zero_compare", compare, 1);
    offer(50, 80);
    step();
    cfg_if.cfg_valid = 1'b0;
    Ctr_0 = 1'b1;
    step();
    Ctr_0 = 1'b0;
    chk("san_cmp_period", period, 50);
    chk("san_cmp_clip", compare, 50);

    // Stop via DRAIN with a pending pair applied at the same boundary
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("drain_clk_en", Clk_en, 1);
    chk("drain_busy", busy, 1);
    offer(300, 40);
    step();
    cfg_if.cfg_valid = 1'b0;
    step();
    chk("drain_hold_clk_en", Clk_en, 1);
    chk("drain_hold_period", period, 50);
    Ctr_0 = 1'b1;
    step();
    Ctr_0 = 1'b0;
    chk("stop_clk_en", Clk_en, 0);
    chk("stop_busy", busy, 0);
    chk("stop_apply_period", period, 300);
    chk("stop_apply_compare", compare, 40);
    chk("stop_apply_pulse", upd_done, 1);

    // Idle update: visible after the edge following the transfer
    offer(123, 45);
    step();
    cfg_if.cfg_valid = 1'b0;
    chk("idle_upd_hold", period, 300);
    chk("idle_upd_ready_low", cfg_if.cfg_ready, 0);
    step();
    chk("idle_upd_period", period, 123);
    chk("idle_upd_compare", compare, 45);
    chk("idle_upd_pulse", upd_done, 1);
    step();
    chk("idle_upd_ready", cfg_if.cfg_ready, 1);

    // Reset mid-DRAIN discards the pending pair
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    stop = 1'b1;
    step();
    stop = 1'b0;
    offer(700, 9);
    step();
    cfg_if.cfg_valid = 1'b0;
    chk("mid_rst_pending", cfg_if.cfg_ready, 0);
    chk("mid_rst_busy_before", busy, 1);
    Rst = 1'b1;
    step();
    Rst = 1'b0;
    chk("mid_rst_period", period, 1000);
    chk("mid_rst_compare", compare, 20);
    chk("mid_rst_ready", cfg_if.cfg_ready, 1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_clk_en", Clk_en, 0);
    chk("mid_rst_no_pulse", upd_done, 0);
    step();
    chk("mid_rst_no_pulse2", upd_done, 0);
    chk("mid_rst_period2", period, 1000);

    // Randomized traffic checked by the model
    for (int i = 0; i < 4000; i++) begin
      Rst   = ($urandom_range(0, 299) == 0);
      start = ($urandom_range(0, 7) == 0);
      stop  = ($urandom_range(0, 15) == 0);
      Ctr_0 = ($urandom_range(0, 5) == 0);
      cfg_if.cfg_valid   = ($urandom_range(0, 2) == 0);
      cfg_if.cfg_period  = ($urandom_range(0, 3) == 0) ? 12'($urandom_range(0, 3)) : 12'($urandom);
      cfg_if.cfg_compare = 12'($urandom);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
